// File: rtl/nor_seq_if.sv
// nor_seq_if: groups the request, operand, result and external NOR-gate signals of nor_seq.
// Ports: start/op/a/b request an operation; nor_a/nor_b/nor_y connect to the shared external gates;
//        busy/done/result report progress and the final value. The master modport is the environment side.
interface nor_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] nor_a;
   logic [WIDTH-1:0] nor_b;
   logic [WIDTH-1:0] nor_y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a, b, nor_y,
      input  nor_a, nor_b, busy, done, result
   );

   modport slave (
      input  start, op, a, b, nor_y,
      output nor_a, nor_b, busy, done, result
   );
endinterface

// File: rtl/nor_seq.sv
// nor_seq: builds 8 logic functions from a sequence of single NORs on an external shared 7402 bank.
// Latency: accept edge, then one cycle per NOR step, then one DONE cycle (done pulse, busy still high).
// Backpressure: start is only sampled in IDLE; requests in STEP or DONE are ignored, not queued.
// Ports: clk, rst (async active-high); bus (slave modport): start/op/a/b in, nor_a/nor_b out, nor_y in,
//        busy/done/result out.
module nor_seq #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   nor_seq_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;
   typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T1, SRC_T2, SRC_T3} src_t;
   typedef enum logic [1:0] {DST_T1, DST_T2, DST_T3, DST_R} dst_t;

   state_t           r_state;
   state_t           w_next;
   logic [2:0]       r_cnt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_t1;
   logic [WIDTH-1:0] r_t2;
   logic [WIDTH-1:0] r_t3;
   logic [WIDTH-1:0] r_result;

   src_t             w_sx;
   src_t             w_sy;
   dst_t             w_dst;
   logic             w_last;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;

   function automatic logic [WIDTH-1:0] pick(input src_t s,
                                             input logic [WIDTH-1:0] a,  input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] t1, input logic [WIDTH-1:0] t2,
                                             input logic [WIDTH-1:0] t3);
      case (s)
         SRC_A:   return a;
         SRC_B:   return b;
         SRC_T1:  return t1;
         SRC_T2:  return t2;
         default: return t3;
      endcase
   endfunction

   // Microcode: gate sources, destination and last-step flag for (op, step).
   // Counter values past an op's length are unreachable; they fall into the final step's entry.
   always_comb begin
      w_sx   = SRC_A;
      w_sy   = SRC_A;
      w_dst  = DST_R;
      w_last = 1'b1;
      case (r_op)
         3'b000: w_sy = SRC_B;
         3'b001: begin
            if (r_cnt == 3'd0) begin
               w_sy = SRC_B; w_dst = DST_T1; w_last = 1'b0;
            end else begin
               w_sx = SRC_T1; w_sy = SRC_T1;
            end
         end
         3'b010: ;
         3'b011: begin
            case (r_cnt)
               3'd0:    begin w_dst = DST_T1; w_last = 1'b0; end
               3'd1:    begin w_sx = SRC_B; w_sy = SRC_B; w_dst = DST_T2; w_last = 1'b0; end
               default: begin w_sx = SRC_T1; w_sy = SRC_T2; end
            endcase
         end
         3'b100: begin
            case (r_cnt)
               3'd0:    begin w_dst = DST_T1; w_last = 1'b0; end
               3'd1:    begin w_sx = SRC_B; w_sy = SRC_B; w_dst = DST_T2; w_last = 1'b0; end
               3'd2:    begin w_sx = SRC_T1; w_sy = SRC_T2; w_dst = DST_T3; w_last = 1'b0; end
               default: begin w_sx = SRC_T3; w_sy = SRC_T3; end
            endcase
         end
         3'b101, 3'b110: begin
            // XNOR prefix shared by both ops; XOR adds a final inversion through T1.
            case (r_cnt)
               3'd0:    begin w_sy = SRC_B; w_dst = DST_T1; w_last = 1'b0; end
               3'd1:    begin w_sy = SRC_T1; w_dst = DST_T2; w_last = 1'b0; end
               3'd2:    begin w_sx = SRC_B; w_sy = SRC_T1; w_dst = DST_T3; w_last = 1'b0; end
               3'd3:    begin
                  w_sx = SRC_T2; w_sy = SRC_T3;
                  if (r_op == 3'b110) begin
                     w_dst = DST_T1; w_last = 1'b0;
                  end
               end
               default: begin w_sx = SRC_T1; w_sy = SRC_T1; end
            endcase
         end
         default: begin
            if (r_cnt == 3'd0) begin
               w_dst = DST_T1; w_last = 1'b0;
            end else begin
               w_sx = SRC_T1; w_sy = SRC_T1;
            end
         end
      endcase
      w_x = pick(w_sx, r_a, r_b, r_t1, r_t2, r_t3);
      w_y = pick(w_sy, r_a, r_b, r_t1, r_t2, r_t3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_STEP;
         S_STEP:  if (w_last)    w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decode straight from state so reset clears them without a clock edge.
   always_comb begin
      bus.busy   = (r_state != S_IDLE);
      bus.done   = (r_state == S_DONE);
      bus.nor_a  = (r_state == S_STEP) ? w_x : '0;
      bus.nor_b  = (r_state == S_STEP) ? w_y : '0;
      bus.result = r_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_t1     <= '0;
         r_t2     <= '0;
         r_t3     <= '0;
         r_result <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_op  <= bus.op;
         r_a   <= bus.a;
         r_b   <= bus.b;
         r_cnt <= '0;
      end else if (r_state == S_STEP) begin
         case (w_dst)
            DST_T1:  r_t1     <= bus.nor_y;
            DST_T2:  r_t2     <= bus.nor_y;
            DST_T3:  r_t3     <= bus.nor_y;
            default: r_result <= bus.nor_y;
         endcase
         if (!w_last) r_cnt <= r_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_nor_seq.sv
// tb_nor_seq: randomized and directed bench for nor_seq with a 7402 model on nor_y.
// Latency: checks done arrives exactly n+1 cycles after accept for an n-step op.
// Backpressure: checks start is ignored during STEP and DONE.
module tb_nor_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nor_seq_if #(.WIDTH(W)) bus();
   nor_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // External quad NOR gates.
   assign bus.nor_y = ~(bus.nor_a | bus.nor_b);

   typedef struct {
      logic [W-1:0] res;
      int           acc;
      int           done_cyc;
   } exp_t;

   exp_t         sb[$];
   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   logic [W-1:0] held     = '0;
   logic         prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         3'd0:    return ~(a | b);
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return a & b;
         3'd4:    return ~(a & b);
         3'd5:    return ~(a ^ b);
         3'd6:    return a ^ b;
         default: return a;
      endcase
   endfunction

   function automatic int nsteps(input logic [2:0] op);
      case (op)
         3'd0, 3'd2: return 1;
         3'd1, 3'd7: return 2;
         3'd3:       return 3;
         3'd4, 3'd5: return 4;
         default:    return 5;
      endcase
   endfunction

   // Expected gate inputs {nor_a, nor_b} for step k, with temporaries in closed form.
   function automatic logic [2*W-1:0] step_pair(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input int k);
      logic [W-1:0] t1, t2, t3;
      t1 = ~(a | b);
      t2 = ~(a | t1);
      t3 = ~(b | t1);
      case (op)
         3'd0: return {a, b};
         3'd1: if (k == 0) return {a, b}; else return {t1, t1};
         3'd2: return {a, a};
         3'd3: begin
            if (k == 0) return {a, a};
            if (k == 1) return {b, b};
            return {~a, ~b};
         end
         3'd4: begin
            if (k == 0) return {a, a};
            if (k == 1) return {b, b};
            if (k == 2) return {~a, ~b};
            return {a & b, a & b};
         end
         3'd5, 3'd6: begin
            if (k == 0) return {a, b};
            if (k == 1) return {a, t1};
            if (k == 2) return {b, t1};
            if (k == 3) return {t2, t3};
            return {~(a ^ b), ~(a ^ b)};
         end
         default: if (k == 0) return {a, a}; else return {~a, ~a};
      endcase
   endfunction

   // Monitor: pops the scoreboard on every done pulse and watches protocol invariants.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held      = '0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) begin
            check("done_width", 32'(bus.done), 32'd0);
            check("idle_after_done", 32'(bus.busy), 32'd0);
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("result", 32'(bus.result), 32'(e.res));
               check("latency", 32'(cyc), 32'(e.done_cyc));
               check("busy_in_done", 32'(bus.busy), 32'd1);
               held = e.res;
            end
         end else begin
            check("result_held", 32'(bus.result), 32'(held));
            if (sb.size() > 0 && cyc >= sb[0].acc)
               check("busy_in_op", 32'(bus.busy), 32'd1);
         end
         prev_done = bus.done;
      end
   end

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done in 12 cycles want done (cycle %0d)", cyc);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int               acc;
      int               n;
      logic [2*W-1:0]   p;
      n = nsteps(op);
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back('{res: ref_res(op, a, b), acc: acc, done_cyc: acc + n});
      // Scramble inputs after accept; the latched copy must be used.
      bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 3'($urandom);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         p = step_pair(op, a, b, k);
         check("nor_a", 32'(bus.nor_a), 32'(p[2*W-1:W]));
         check("nor_b", 32'(bus.nor_b), 32'(p[W-1:0]));
      end
      wait_done();
   endtask

   initial begin
      int acc;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_nor_a", 32'(bus.nor_a), 32'd0);
      check("rst_nor_b", 32'(bus.nor_b), 32'd0);
      #1 rst = 1'b0;

      run_op(3'b011, 8'hF0, 8'hCC);
      run_op(3'b110, 8'hAA, 8'h0F);
      run_op(3'b101, 8'hAA, 8'h0F);

      // start held and operands changed mid-operation, then held through DONE.
      @(negedge clk);
      bus.op = 3'b011; bus.a = 8'hF0; bus.b = 8'hCC; bus.start = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back('{res: 8'hC0, acc: acc, done_cyc: acc + 3});
      bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 3'b000;
      wait_done();
      @(posedge clk); @(posedge clk); #1;
      sb.push_back('{res: 8'h00, acc: acc + 5, done_cyc: acc + 6});
      bus.start = 1'b0;
      wait_done();

      for (int op = 0; op < 8; op++) run_op(3'(op), 8'h3C, 8'h56);

      repeat (40) run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      run_op(3'b111, 8'h3C, 8'h56);

      // Asynchronous reset during the second step of XOR.
      @(negedge clk);
      bus.op = 3'b110; bus.a = 8'hAA; bus.b = 8'h0F; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_result", 32'(bus.result), 32'd0);
      check("arst_nor_a", 32'(bus.nor_a), 32'd0);
      check("arst_nor_b", 32'(bus.nor_b), 32'd0);
      sb.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      run_op(3'b000, 8'h00, 8'h00);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish by 200000");
      $fatal(1);
   end

endmodule

// File: doc/nor_seq.md
NOR_SEQ -- requirements
Module: nor_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (one 7402 per 4 bits).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  3  operation select, latched on accept.
REQ-006 a, b  input  WIDTH each  operands, latched on accept.
REQ-007 nor_a, nor_b  output  WIDTH each  drive to the inputs of the external shared NOR gates.
REQ-008 nor_y  input  WIDTH  return from the external NOR gates; combinational function of nor_a/nor_b.
REQ-009 busy  output  1  high while an operation is in progress, from STEP through DONE.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  WIDTH  final value; held until the next accept.

Function
REQ-012 The FSM SHALL have states IDLE, STEP and DONE, plus a step counter of 3 bits.
- IDLE -> STEP when start=1: latch a, b and op; clear the counter.
- STEP -> DONE after the last step of op.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 Each STEP cycle SHALL perform exactly one NOR.
- nor_a and nor_b are selected combinationally from {A, B, T1, T2, T3} per the op/step table.
- nor_y is captured at the end of the cycle into the step's destination: T1, T2, T3 or result.
REQ-014 Op table: dest=NOR(x,y) per step, one step per arrow; op 111 is buffer, not reserved.
- 000 NOR (1 step): R=(A,B).
- 001 OR (2 steps): T1=(A,B) -> R=(T1,T1).
- 010 NOTA (1 step): R=(A,A).
- 011 AND (3 steps): T1=(A,A) -> T2=(B,B) -> R=(T1,T2).
- 100 NAND (4 steps): T1=(A,A) -> T2=(B,B) -> T3=(T1,T2) -> R=(T3,T3).
- 101 XNOR (4 steps): T1=(A,B) -> T2=(A,T1) -> T3=(B,T1) -> R=(T2,T3).
- 110 XOR (5 steps): XNOR sequence with T1..T3, then T1=(T2,T3) -> R=(T1,T1).
- 111 BUFA (2 steps): T1=(A,A) -> R=(T1,T1).
REQ-015 Latency SHALL be deterministic.
- Accept at rising edge E0.
- STEP cycles occupy E0..E(n), where n = the op's step count.
- done=1 and busy=1 during the single cycle after E(n).
- busy=0 from the following edge onward.
REQ-016 start SHALL be ignored in STEP and DONE; a, b and op changes after accept SHALL NOT affect the operation.
REQ-017 In IDLE and DONE, nor_a and nor_b SHALL be all zeros.
REQ-018 result SHALL change only on the final step's edge.
- Intermediate steps never disturb result.
- The previous result is visible until then.
REQ-019 Back-to-back: start=1 during DONE is not accepted; the earliest next accept is the first IDLE cycle.
REQ-020 The step counter SHALL NOT wrap: the maximum count reached is 4 (5 steps), and values beyond the op length are unreachable.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, force the following, including mid-STEP:
- state=IDLE, counter=0, T1..T3=0;
- result=0, busy=0, done=0, nor_a=nor_b=0.
REQ-022 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios (WIDTH=8):
- AND: a=0xF0, b=0xCC, op=011 -> 3 STEP cycles, done pulse on the 4th cycle after accept, result=0xC0.
- XOR: a=0xAA, b=0x0F, op=110 -> 5 STEP cycles, result=0xA5; XNOR on the same operands (op=101) -> result=0x5A in 4 steps.
- Full sweep: every op with a=0x3C, b=0x56.
  - Expected results: NOR=0x81, OR=0x7E, NOTA=0xC3, AND=0x14, NAND=0xEB, XNOR=0x95, XOR=0x6A, BUFA=0x3C.
  - nor_a/nor_b are checked each step against the table.
- start pulsed mid-operation, with a/b changed to 0xFF: no restart and result unaffected; start held through DONE is accepted only in the next IDLE cycle.
- rst asserted asynchronously during step 2 of XOR -> all outputs zero before the next clk edge; the post-reset NOR of 0x00,0x00 returns 0xFF.
- Bench model of 7402 behaviour on nor_y: verify done is exactly one cycle wide and busy never deasserts between accept and done.
